// File: rtl/fft_stage_sequencer_pkg.sv
// Shared constants and types for the FFT stage sequencer.
// Stage/step geometry, FSM encoding and frame latency.
package fft_ctrl_pkg;

   localparam int NUM_STAGES  = 5;
   localparam int MAC_STEPS   = 5;
   localparam int SEL_WIDTH   = 3;
   localparam int STAGE_WIDTH = 3;

   localparam int FRAME_LATENCY = 2 + NUM_STAGES * MAC_STEPS;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_DONE
   } state_e;

   typedef logic [SEL_WIDTH-1:0]   sel_t;
   typedef logic [STAGE_WIDTH-1:0] stage_t;

   localparam sel_t   SEL_LAST   = sel_t'(MAC_STEPS - 1);
   localparam stage_t STAGE_LAST = stage_t'(NUM_STAGES - 1);

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Control/status bundle between the sequencer and its requester.
// The sequencer is the slave; the requester drives start/abort/out_ready.
interface fft_stage_sequencer_if;
   import fft_ctrl_pkg::*;

   logic   start;
   logic   abort;
   logic   out_ready;
   logic   load_en;
   logic   PU_enable;
   sel_t   sel;
   stage_t stage;
   logic   stage_capture;
   logic   busy;
   logic   out_valid;

   modport master (
      output start, abort, out_ready,
      input  load_en, PU_enable, sel, stage,
      input  stage_capture, busy, out_valid
   );

   modport slave (
      input  start, abort, out_ready,
      output load_en, PU_enable, sel, stage,
      output stage_capture, busy, out_valid
   );

endinterface

// File: rtl/fft_stage_sequencer_step_counter.sv
// Modulo-MAC_STEPS micro-op counter with enable and synchronous clear.
// wrap is a registered flag that is high exactly while sel sits at its last step.
module fft_step_counter
   import fft_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output sel_t sel,
   output logic wrap
);

   sel_t sel_q, sel_d;
   logic wrap_q, wrap_d;

   always_comb begin
      sel_d = sel_q;
      if (clr) begin
         sel_d = '0;
      end else if (en) begin
         sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + sel_t'(1);
      end
      wrap_d = (sel_d == SEL_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         sel_q  <= sel_d;
         wrap_q <= wrap_d;
      end
   end

   assign sel  = sel_q;
   assign wrap = wrap_q;

endmodule

// File: rtl/fft_stage_sequencer.sv
// FSM sequencing the 32-point radix-2 FFT datapath through its stages.
// All outputs are registered Moore outputs decoded from the next state.
module fft_stage_sequencer
   import fft_ctrl_pkg::*;
(
   input logic                  clk,
   input logic                  reset,
   fft_stage_sequencer_if.slave bus
);

   state_e state_q, state_d;
   stage_t stage_q, stage_d;
   logic   load_en_q, load_en_d;
   logic   pu_q, pu_d;
   logic   busy_q, busy_d;
   logic   valid_q, valid_d;

   sel_t   sel;
   logic   wrap;
   logic   cnt_en;
   logic   cnt_clr;

   assign cnt_en  = (state_q == ST_RUN);
   assign cnt_clr = bus.abort || (state_q != ST_RUN);

   fft_step_counter u_step (
      .clk   (clk),
      .rst_n (reset),
      .en    (cnt_en),
      .clr   (cnt_clr),
      .sel   (sel),
      .wrap  (wrap)
   );

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      if (bus.abort) begin
         state_d = ST_IDLE;
         stage_d = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (bus.start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
               state_d = ST_RUN;
               stage_d = '0;
            end
            ST_RUN: begin
               if (wrap) begin
                  if (stage_q == STAGE_LAST) state_d = ST_DONE;
                  else stage_d = stage_q + stage_t'(1);
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  state_d = ST_IDLE;
                  stage_d = '0;
               end
            end
         endcase
      end
      load_en_d = (state_d == ST_LOAD);
      pu_d      = (state_d == ST_RUN);
      busy_d    = (state_d != ST_IDLE);
      valid_d   = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         stage_q   <= '0;
         load_en_q <= 1'b0;
         pu_q      <= 1'b0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         stage_q   <= stage_d;
         load_en_q <= load_en_d;
         pu_q      <= pu_d;
         busy_q    <= busy_d;
         valid_q   <= valid_d;
      end
   end

   assign bus.load_en       = load_en_q;
   assign bus.PU_enable     = pu_q;
   assign bus.sel           = sel;
   assign bus.stage         = stage_q;
   assign bus.stage_capture = wrap;
   assign bus.busy          = busy_q;
   assign bus.out_valid     = valid_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed and random stimulus against a frame-timeline reference model.
// Model tracks cycles since frame start and derives every output arithmetically.
module tb_fft_stage_sequencer;
   import fft_ctrl_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   fft_stage_sequencer_if bus ();

   fft_stage_sequencer dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: m_k = cycles since LOAD; 0 load, 1..25 run, 26 done.
   bit m_act;
   int m_k;

   task automatic model_edge(input bit s, input bit a, input bit r);
      if (a) m_act = 0;
      else if (!m_act) begin
         if (s) begin
            m_act = 1;
            m_k   = 0;
         end
      end else if (m_k < FRAME_LATENCY - 1) m_k++;
      else if (r) m_act = 0;
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      bit run, done;
      int r;
      int e_sel, e_stage;
      run  = m_act && m_k >= 1 && m_k <= NUM_STAGES * MAC_STEPS;
      done = m_act && m_k == FRAME_LATENCY - 1;
      r    = m_k - 1;
      e_sel   = run ? r % MAC_STEPS : 0;
      e_stage = run ? r / MAC_STEPS : (done ? NUM_STAGES - 1 : 0);
      chk({tag, ".load_en"}, 32'(bus.load_en), 32'(m_act && m_k == 0));
      chk({tag, ".pu"}, 32'(bus.PU_enable), 32'(run));
      chk({tag, ".sel"}, 32'(bus.sel), 32'(e_sel));
      chk({tag, ".stage"}, 32'(bus.stage), 32'(e_stage));
      chk({tag, ".cap"}, 32'(bus.stage_capture),
          32'(run && e_sel == MAC_STEPS - 1));
      chk({tag, ".busy"}, 32'(bus.busy), 32'(m_act));
      chk({tag, ".valid"}, 32'(bus.out_valid), 32'(done));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      if (!rst_n) m_act = 0;
      else model_edge(bus.start, bus.abort, bus.out_ready);
      #1;
      check_all(tag);
   endtask

   task automatic run_to(input int k, input string tag);
      int n;
      n = 0;
      while (!(m_act && m_k == k) && n < 40) begin
         step(tag);
         n++;
      end
      chk({tag, ".reach"}, 32'(m_act && m_k == k), 32'd1);
   endtask

   initial begin
      int pu_cnt, ld_cnt, cap_cnt, ov_cnt, cap4;
      int cyc, cyc_ov, cyc_ld;
      checks = 0;
      errors = 0;
      m_act  = 0;
      m_k    = 0;
      rst_n  = 1'b0;
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.out_ready = 1'b0;

      #1;
      check_all("reset");
      step("reset");
      step("reset");
      rst_n = 1'b1;
      step("idle");

      // Single frame with immediate acceptance
      bus.out_ready = 1'b1;
      bus.start = 1'b1;
      pu_cnt = 0; ld_cnt = 0; cap_cnt = 0; ov_cnt = 0; cap4 = 0;
      for (int i = 0; i < 30; i++) begin
         step("frame");
         bus.start = 1'b0;
         pu_cnt  += int'(bus.PU_enable);
         ld_cnt  += int'(bus.load_en);
         cap_cnt += int'(bus.stage_capture);
         ov_cnt  += int'(bus.out_valid);
         if (bus.stage_capture && bus.sel == SEL_LAST) cap4++;
      end
      chk("frame.pu_cycles", 32'(pu_cnt), 32'd25);
      chk("frame.loads", 32'(ld_cnt), 32'd1);
      chk("frame.captures", 32'(cap_cnt), 32'd5);
      chk("frame.cap_at_sel4", 32'(cap4), 32'd5);
      chk("frame.valids", 32'(ov_cnt), 32'd1);

      // Downstream stall in DONE, start pulses ignored
      bus.out_ready = 1'b0;
      bus.start = 1'b1;
      step("stall");
      bus.start = 1'b0;
      run_to(FRAME_LATENCY - 1, "stall");
      ov_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         ov_cnt += int'(bus.out_valid);
         bus.start = 1'($urandom_range(0, 1));
         step("stall.hold");
      end
      chk("stall.valid_cycles", 32'(ov_cnt), 32'd10);
      bus.start = 1'b1;
      bus.out_ready = 1'b1;
      step("stall.accept");
      bus.start = 1'b0;
      chk("stall.idle", 32'(bus.busy), 32'd0);
      step("stall.idle");

      // Abort at stage 3, sel 1, then a clean frame
      bus.start = 1'b1;
      step("abort");
      bus.start = 1'b0;
      run_to(17, "abort");
      bus.abort = 1'b1;
      step("abort.hit");
      bus.abort = 1'b0;
      chk("abort.busy", 32'(bus.busy), 32'd0);
      bus.start = 1'b1;
      ov_cnt = 0; pu_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         step("abort.next");
         bus.start = 1'b0;
         ov_cnt += int'(bus.out_valid);
         pu_cnt += int'(bus.PU_enable);
      end
      chk("abort.next_valid", 32'(ov_cnt), 32'd1);
      chk("abort.next_pu", 32'(pu_cnt), 32'd25);

      // Asynchronous reset at stage 2, sel 3
      bus.start = 1'b1;
      step("rst");
      bus.start = 1'b0;
      run_to(14, "rst");
      chk("rst.pre_stage", 32'(bus.stage), 32'd2);
      #2;
      rst_n = 1'b0;
      m_act = 0;
      #1;
      check_all("rst.async");
      step("rst.hold");
      rst_n = 1'b1;
      step("rst.release");

      // Back-to-back frames with start held high
      bus.start = 1'b1;
      bus.out_ready = 1'b1;
      cyc = 0; cyc_ov = -1; cyc_ld = -1;
      for (int i = 0; i < 70; i++) begin
         step("b2b");
         cyc++;
         if (bus.out_valid && cyc_ov < 0) cyc_ov = cyc;
         if (bus.load_en && cyc_ov >= 0 && cyc_ld < 0) cyc_ld = cyc;
      end
      chk("b2b.gap", 32'(cyc_ld - cyc_ov), 32'd2);
      bus.start = 1'b0;

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         bus.start     = 1'($urandom_range(0, 1));
         bus.abort     = ($urandom_range(0, 29) == 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         step("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
